lut_layer_sequencer: RTL and testbench

LUT_LAYER_SEQUENCER -- requirements
Module: lut_layer_sequencer

---
 rtl/lut_seq_pkg.sv | 32 +++
 rtl/lut_seq_ram.sv | 33 +++
 rtl/lut_layer_sequencer.sv | 147 ++++++++++++++
 tb/tb_lut_layer_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lut_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_seq_pkg
// Description : Default parameters, derived widths and state encoding for the
//               LUT layer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lut_seq_pkg;

  localparam int DEF_NUM_NEURONS = 32;
  localparam int DEF_IN_WIDTH    = 64;
  localparam int DEF_FANIN       = 4;
  localparam int DEF_BW          = 2;
  localparam int DEF_OUT_BW      = 2;

  // LUT address width and connectivity field-index width at the defaults
  localparam int AW = DEF_FANIN * DEF_BW;
  localparam int IW = $clog2(DEF_IN_WIDTH / DEF_BW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : lut_seq_pkg
`default_nettype wire

// File: rtl/lut_seq_ram.sv
`default_nettype none
// ============================================================================
// Module      : lut_seq_ram
// Description : Simple 1R1W RAM, synchronous read with one-cycle latency.
//               Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_seq_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule : lut_seq_ram
`default_nettype wire

// File: rtl/lut_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lut_layer_sequencer
// Description : Evaluates one layer of LUT neurons per accepted input vector.
//               Neurons are processed one per cycle through a three-stage
//               pipeline: connectivity read -> LUT read -> result write.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_layer_sequencer
  import lut_seq_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int FANIN       = DEF_FANIN,
  parameter int BW          = DEF_BW,
  parameter int OUT_BW      = DEF_OUT_BW
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IN_WIDTH-1:0]                    in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_NEURONS*OUT_BW-1:0]          out_data,
  input  logic                                   cfg_we,
  input  logic                                   cfg_sel,
  input  logic [$clog2(NUM_NEURONS)+FANIN*BW-1:0] cfg_addr,
  input  logic [max_int(OUT_BW, FANIN*$clog2(IN_WIDTH/BW))-1:0] cfg_data,
  output logic                                   cfg_err
);

  localparam int c_AW   = FANIN * BW;
  localparam int c_NF   = IN_WIDTH / BW;
  localparam int c_IW   = $clog2(c_NF);
  localparam int c_NW   = $clog2(NUM_NEURONS);
  localparam int c_CNTW = c_NW + 1;
  localparam logic [c_CNTW-1:0] c_CNT_END = c_CNTW'(NUM_NEURONS);

  state_t                        r_state, w_next;
  logic [c_CNTW-1:0]             r_cnt;
  logic                          r_drain;
  logic [IN_WIDTH-1:0]           r_in;
  logic                          r_v1, r_v2;
  logic [c_NW-1:0]               r_n1, r_n2;
  logic [NUM_NEURONS*OUT_BW-1:0] r_out;
  logic                          r_err;

  logic                          w_idle, w_accept, w_cfg_ok, w_conn_re;
  logic [FANIN*c_IW-1:0]         w_conn_rd;
  logic [OUT_BW-1:0]             w_lut_rd;
  logic [c_AW-1:0]               w_lut_addr;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = in_valid && w_idle;
  assign w_cfg_ok  = cfg_we && w_idle;
  // The counter runs one step past the last neuron to mark the end of RUN
  assign w_conn_re = (r_state == ST_RUN) && (r_cnt < c_CNT_END);

  assign in_ready  = w_idle;
  assign out_valid = (r_state == ST_HOLD);
  assign out_data  = r_out;
  assign cfg_err   = r_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid)            w_next = ST_RUN;
      ST_RUN:   if (r_cnt == c_CNT_END)  w_next = ST_DRAIN;
      ST_DRAIN: if (r_drain)             w_next = ST_HOLD;
      ST_HOLD:  if (out_ready)           w_next = ST_IDLE;
      default:                           w_next = ST_IDLE;
    endcase
  end

  // Counter, pipeline tags, result register and sticky config error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_drain <= 1'b0;
      r_in    <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_n1    <= '0;
      r_n2    <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_v1    <= w_conn_re;
      r_n1    <= r_cnt[c_NW-1:0];
      r_v2    <= r_v1;
      r_n2    <= r_n1;
      r_drain <= (r_state == ST_DRAIN) && !r_drain;
      if (cfg_we && !w_idle) r_err <= 1'b1;
      if (w_accept) begin
        r_in  <= in_data;
        r_cnt <= '0;
        r_out <= '0;
      end else if (w_conn_re) begin
        r_cnt <= r_cnt + c_CNTW'(1);
      end
      if (r_v2) r_out[OUT_BW*r_n2 +: OUT_BW] <= w_lut_rd;
    end
  end

  // LUT address: slot k's selected input field lands in address bits k
  for (genvar k = 0; k < FANIN; k++) begin : g_slot
    logic [c_IW-1:0] w_f;
    assign w_f = w_conn_rd[c_IW*k +: c_IW];
    assign w_lut_addr[BW*k +: BW] = (32'(w_f) < c_NF) ? r_in[BW*w_f +: BW] : '0;
  end

  lut_seq_ram #(
    .ADDR_W (c_NW),
    .DATA_W (FANIN*c_IW)
  ) u_conn_ram (
    .clk     (clk),
    .i_we    (w_cfg_ok && cfg_sel),
    .i_waddr (cfg_addr[c_NW+c_AW-1 -: c_NW]),
    .i_wdata (cfg_data[FANIN*c_IW-1:0]),
    .i_re    (w_conn_re),
    .i_raddr (r_cnt[c_NW-1:0]),
    .o_rdata (w_conn_rd)
  );

  lut_seq_ram #(
    .ADDR_W (c_NW+c_AW),
    .DATA_W (OUT_BW)
  ) u_lut_ram (
    .clk     (clk),
    .i_we    (w_cfg_ok && !cfg_sel),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data[OUT_BW-1:0]),
    .i_re    (r_v1),
    .i_raddr ({r_n1, w_lut_addr}),
    .o_rdata (w_lut_rd)
  );

endmodule : lut_layer_sequencer
`default_nettype wire

// File: tb/tb_lut_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_layer_sequencer
// Description : Directed self-checking bench for lut_layer_sequencer. A
//               default-sized instance covers the main flow; a small instance
//               with 40 input fields covers out-of-range field indices.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_layer_sequencer;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [63:0] out_data;
  logic        cfg_we = 1'b0, cfg_sel = 1'b0, cfg_err;
  logic [12:0] cfg_addr = '0;
  logic [19:0] cfg_data = '0;

  logic        in_valid_b = 1'b0, in_ready_b;
  logic [79:0] in_data_b = '0;
  logic        out_valid_b, out_ready_b = 1'b1;
  logic [7:0]  out_data_b;
  logic        cfg_we_b = 1'b0, cfg_sel_b = 1'b0, cfg_err_b;
  logic [9:0]  cfg_addr_b = '0;
  logic [23:0] cfg_data_b = '0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lut_layer_sequencer u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err)
  );

  lut_layer_sequencer #(.NUM_NEURONS(4), .IN_WIDTH(80)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .cfg_we(cfg_we_b), .cfg_sel(cfg_sel_b), .cfg_addr(cfg_addr_b),
    .cfg_data(cfg_data_b), .cfg_err(cfg_err_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic sel, input logic [12:0] addr, input logic [19:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wr_b(input logic sel, input logic [9:0] addr, input logic [23:0] data);
    cfg_we_b = 1'b1; cfg_sel_b = sel; cfg_addr_b = addr; cfg_data_b = data;
    step();
    cfg_we_b = 1'b0;
  endtask

  // act: 0 plain, 1 cfg write mid-RUN, 2 reset mid-pass, 3 cfg write on accept
  task automatic run_pass(input string tag, input logic [7:0] d,
                          input logic [1:0] e0, input logic [1:0] e31, input int act);
    logic seen;
    seen = 1'b0;
    in_data  = {56'h0, d};
    in_valid = 1'b1;
    if (act == 3) begin
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = {5'd0, 8'h23}; cfg_data = 20'd3;
    end
    chk({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    chk({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
    if (act == 2) begin
      for (int k = 1; k <= N + 6; k++) begin
        if (k == 10) rst = 1'b1;
        step();
        rst = 1'b0;
        if (out_valid) seen = 1'b1;
      end
      chk({tag, " no out_valid"}, 64'(seen), 64'd0);
      chk({tag, " in_ready after rst"}, 64'(in_ready), 64'd1);
      chk({tag, " out_data after rst"}, out_data, 64'd0);
      chk({tag, " cfg_err after rst"}, 64'(cfg_err), 64'd0);
    end else begin
      for (int k = 1; k <= N + 2; k++) begin
        if (act == 1 && k == 5) begin
          cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = {5'd0, 8'h23}; cfg_data = 20'd0;
        end
        step();
        cfg_we = 1'b0;
      end
      chk({tag, " out_valid at N+2"}, 64'(out_valid), 64'd0);
      step();
      chk({tag, " out_valid at N+3"}, 64'(out_valid), 64'd1);
      chk({tag, " neuron0"}, 64'(out_data[1:0]), 64'(e0));
      chk({tag, " neuron31"}, 64'(out_data[63:62]), 64'(e31));
    end
  endtask

  task automatic release_chk(input string tag);
    step();
    chk({tag, " back to idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    // Reset state
    step(); step(); step();
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", out_data, 64'd0);
    chk("rst cfg_err", 64'(cfg_err), 64'd0);
    rst = 1'b0;
    step();

    // Neuron 0: 0x23 -> 01; neuron 31: 0xC8 -> 10; all else 00
    for (int a = 0; a < 256; a++) begin
      wr_a(1'b0, {5'd0,  8'(a)}, (a == 8'h23) ? 20'd1 : 20'd0);
      wr_a(1'b0, {5'd31, 8'(a)}, (a == 8'hC8) ? 20'd2 : 20'd0);
    end
    wr_a(1'b1, {5'd0,  8'h00}, {5'd3, 5'd2, 5'd1, 5'd0});
    wr_a(1'b1, {5'd31, 8'hAB}, {5'd0, 5'd1, 5'd2, 5'd3});

    // Second instance: slot0 index 40 (out of range), slot1 index 39 (last)
    for (int a = 0; a < 256; a++)
      wr_b(1'b0, {2'd0, 8'(a)}, (a == 8'h28) ? 24'd3 : ((a == 8'h2B) ? 24'd1 : 24'd0));
    wr_b(1'b1, {2'd0, 8'h00}, {6'd3, 6'd2, 6'd39, 6'd40});

    run_pass("p23", 8'h23, 2'b01, 2'b10, 0);
    release_chk("p23");
    run_pass("p63", 8'h63, 2'b00, 2'b00, 0);
    release_chk("p63");

    // Back-pressure: result held while out_ready is low
    out_ready = 1'b0;
    run_pass("hold", 8'h23, 2'b01, 2'b10, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold stable", 64'({out_valid, in_ready, out_data[1:0], out_data[63:62]}),
          64'({1'b1, 1'b0, 2'b01, 2'b10}));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold release in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // Configuration write while busy is dropped and flagged
    run_pass("cfgrun", 8'h23, 2'b01, 2'b10, 1);
    chk("cfgrun cfg_err", 64'(cfg_err), 64'd1);
    release_chk("cfgrun");

    // Reset mid-pass, then rerun with RAM contents intact
    run_pass("abort", 8'h23, 2'b00, 2'b00, 2);
    run_pass("rerun", 8'h23, 2'b01, 2'b10, 0);
    release_chk("rerun");

    // Config write and input accept in the same idle cycle
    run_pass("same", 8'h23, 2'b11, 2'b10, 3);
    chk("same cfg_err", 64'(cfg_err), 64'd0);
    release_chk("same");

    // Out-of-range field index reads as zero
    in_data_b  = {2'b10, 70'd0, 8'h23};
    in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    chk("oor out_valid at N+2", 64'(out_valid_b), 64'd0);
    step();
    chk("oor out_valid at N+3", 64'(out_valid_b), 64'd1);
    chk("oor neuron0", 64'(out_data_b[1:0]), 64'd3);
    step();
    chk("oor idle", 64'({in_ready_b, cfg_err_b}), 64'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_lut_layer_sequencer
`default_nettype wire
